// File: rtl/vga_timing_if.sv
// Raster timing bundle driven by vga_timing_gen toward the pixel pipeline and video output stage.
// Carries frame_cnt/in_vblank only when VGA_TIMING_GEN_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int CW = 11
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_end;
    logic          frame_start;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
    logic          in_vblank;
`endif

    modport master (
        output hsync, vsync, de, x, y, line_end, frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
        , output frame_cnt, in_vblank
`endif
    );

    modport slave (
        input hsync, vsync, de, x, y, line_end, frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
        , input frame_cnt, in_vblank
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal + vertical raster timing generator built from two chained 4-phase FSMs.
// Optional frame counter and vblank flag enabled by defining VGA_TIMING_GEN_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_SYNC = 80,
    parameter int H_BP   = 160,
    parameter int H_ACT  = 800,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 3,
    parameter int V_BP   = 21,
    parameter int V_ACT  = 600,
    parameter int V_FP   = 1,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CW     = 11
) (
    input  logic           sys_clk,
    input  logic           reset,
    input  logic           ce,
    vga_timing_if.master   vid
);

    typedef enum logic [1:0] {
        SYNC = 2'b00,
        BP   = 2'b01,
        ACT  = 2'b10,
        FP   = 2'b11
    } phase_e;

    if (H_SYNC < 1 || H_SYNC >= (1 << CW) || H_BP < 1 || H_BP >= (1 << CW) ||
        H_ACT  < 1 || H_ACT  >= (1 << CW) || H_FP < 1 || H_FP >= (1 << CW) ||
        V_SYNC < 1 || V_SYNC >= (1 << CW) || V_BP < 1 || V_BP >= (1 << CW) ||
        V_ACT  < 1 || V_ACT  >= (1 << CW) || V_FP < 1 || V_FP >= (1 << CW)) begin : g_param_check
        $error("vga_timing_gen: every length must be >= 1 and fit in CW=%0d bits", CW);
    end

    function automatic logic [CW-1:0] h_last(input phase_e s);
        case (s)
            SYNC:    return CW'(H_SYNC - 1);
            BP:      return CW'(H_BP - 1);
            ACT:     return CW'(H_ACT - 1);
            default: return CW'(H_FP - 1);
        endcase
    endfunction

    function automatic logic [CW-1:0] v_last(input phase_e s);
        case (s)
            SYNC:    return CW'(V_SYNC - 1);
            BP:      return CW'(V_BP - 1);
            ACT:     return CW'(V_ACT - 1);
            default: return CW'(V_FP - 1);
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e s);
        case (s)
            SYNC:    return BP;
            BP:      return ACT;
            ACT:     return FP;
            default: return SYNC;
        endcase
    endfunction

    phase_e        h_state_q, h_state_d;
    phase_e        v_state_q, v_state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_end_q, line_end_d;
    logic          frame_start_q, frame_start_d;
    logic          h_wrap, v_wrap, line_last;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          in_vblank_q, in_vblank_d;
`endif

    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        h_wrap    = (hcnt_q == h_last(h_state_q));
        v_wrap    = (vcnt_q == v_last(v_state_q));
        line_last = (h_state_q == FP) && h_wrap;

        if (ce) begin
            if (h_wrap) begin
                hcnt_d    = '0;
                h_state_d = next_phase(h_state_q);
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            // The vertical axis only moves when the last pixel of a line is consumed.
            if (line_last) begin
                if (v_wrap) begin
                    vcnt_d    = '0;
                    v_state_d = next_phase(v_state_q);
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end
        end

        // Levels describe the state being entered; pulses describe the pixel being consumed.
        hsync_d       = (h_state_d == SYNC) ? HS_POL : ~HS_POL;
        vsync_d       = (v_state_d == SYNC) ? VS_POL : ~VS_POL;
        de_d          = (h_state_d == ACT) && (v_state_d == ACT);
        x_d           = (h_state_d == ACT) ? hcnt_d : '0;
        y_d           = (v_state_d == ACT) ? vcnt_d : '0;
        line_end_d    = ce && line_last;
        frame_start_d = ce && (h_state_q == SYNC) && (hcnt_q == '0) &&
                        (v_state_q == SYNC) && (vcnt_q == '0);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        in_vblank_d   = (v_state_d != ACT);
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            h_state_q     <= SYNC;
            v_state_q     <= SYNC;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsync_q       <= HS_POL;
            vsync_q       <= VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
            frame_cnt_q   <= 16'd0;
            in_vblank_q   <= 1'b1;
`endif
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
            in_vblank_q   <= in_vblank_d;
`endif
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_end    = line_end_q;
    assign vid.frame_start = frame_start_q;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    assign vid.frame_cnt   = frame_cnt_q;
    assign vid.in_vblank   = in_vblank_q;
`endif

endmodule
